// File: rtl/morse_tx_param.sv
// Morse/pulse-pattern serialiser: shifts a left-justified pattern out MSB-first, one bit per DIV
// clocks, then appends GAP zero bit-periods. Define MORSE_TX_REPEAT_EN for the repeat-loop option.
module morse_tx_param #(
    parameter int unsigned PAT_W = 16,
    parameter int unsigned DIV   = 25000000,
    parameter int unsigned GAP   = 3,
    parameter int unsigned DIV_W = 28,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
`ifdef MORSE_TX_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             ready,
    output logic             out,
    output logic             done,
    output logic             busy
);

    // One down-counter serves both the pattern bits and the gap periods.
    localparam int unsigned CNT_MAX = (PAT_W > GAP) ? PAT_W : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DIV_W-1:0] TICK_RELOAD = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_CNT     = CNT_W'(GAP);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bits_q, bits_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               out_q, out_d;
    logic               done_q, done_d;
    logic               tick;
    logic               char_end;
    logic [CNT_W-1:0]   len_eff;

    assign len_eff = (pat_len > LEN_W'(PAT_W)) ? CNT_W'(PAT_W) : CNT_W'(pat_len);
    assign tick    = (div_q == '0);

`ifdef MORSE_TX_REPEAT_EN
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] len_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= '0;
            len_q <= '0;
        end else if (state_q == StIdle && start) begin
            pat_q <= pattern;
            len_q <= len_eff;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            bits_q  <= '0;
            div_q   <= TICK_RELOAD;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            div_q   <= div_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bits_d   = bits_q;
        div_d    = div_q;
        done_d   = 1'b0;
        char_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d = pattern;
                    div_d   = TICK_RELOAD;
                    if (len_eff != '0) begin
                        state_d = StSend;
                        bits_d  = len_eff;
                    end else if (GAP != 0) begin
                        state_d = StGap;
                        bits_d  = GAP_CNT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StSend: begin
                div_d = tick ? TICK_RELOAD : div_q - DIV_W'(1);
                if (tick) begin
                    if (bits_q == CNT_W'(1)) begin
                        if (GAP != 0) begin
                            state_d = StGap;
                            bits_d  = GAP_CNT;
                        end else begin
                            char_end = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q << 1;
                        bits_d  = bits_q - CNT_W'(1);
                    end
                end
            end
            StGap: begin
                div_d = tick ? TICK_RELOAD : div_q - DIV_W'(1);
                if (tick) begin
                    if (bits_q == CNT_W'(1)) begin
                        char_end = 1'b1;
                    end else begin
                        bits_d = bits_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (char_end) begin
            done_d  = 1'b1;
            state_d = StIdle;
            bits_d  = '0;
`ifdef MORSE_TX_REPEAT_EN
            // Reload the latched character straight into the next pass; len_q==0 implies GAP>0.
            if (repeat_en) begin
                shift_d = pat_q;
                if (len_q != '0) begin
                    state_d = StSend;
                    bits_d  = len_q;
                end else begin
                    state_d = StGap;
                    bits_d  = GAP_CNT;
                end
            end
`endif
        end

        out_d = (state_d == StSend) ? shift_d[PAT_W-1] : 1'b0;
    end

    assign ready = (state_q == StIdle);
    assign busy  = (state_q != StIdle);
    assign out   = out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_morse_tx_param.sv
// Self-checking bench for morse_tx_param: directed and random characters checked cycle by cycle
// against a timing model derived from the character-period arithmetic.
module tb_morse_tx_param;

    localparam int PAT_W = 16;
    localparam int DIV   = 4;
    localparam int GAP   = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  pat_len = '0;
    logic        ready, out, done, busy;

    logic        start1 = 1'b0;
    logic [15:0] pattern1 = '0;
    logic [4:0]  pat_len1 = '0;
    logic        ready1, out1, done1, busy1;

`ifdef MORSE_TX_REPEAT_EN
    logic        rpt = 1'b0;
`endif

    int total  = 0;
    int passed = 0;

    morse_tx_param #(.PAT_W(PAT_W), .DIV(DIV), .GAP(GAP), .DIV_W(28)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pattern   (pattern),
        .pat_len   (pat_len),
`ifdef MORSE_TX_REPEAT_EN
        .repeat_en (rpt),
`endif
        .ready     (ready),
        .out       (out),
        .done      (done),
        .busy      (busy)
    );

    morse_tx_param #(.PAT_W(PAT_W), .DIV(1), .GAP(0), .DIV_W(1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start1),
        .pattern   (pattern1),
        .pat_len   (pat_len1),
`ifdef MORSE_TX_REPEAT_EN
        .repeat_en (1'b0),
`endif
        .ready     (ready1),
        .out       (out1),
        .done      (done1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Caller has start asserted ahead of the accept edge. Checks cycles 1..T where
    // T = (len_eff+GAP)*DIV+1 is the done cycle. Optional stray start at ignore_at, reset at abort_at.
    task automatic run_char(input logic [15:0] p, input int len, input int ignore_at,
                            input int abort_at);
        int le;
        int t_done;
        logic e_out;
        le     = (len > PAT_W) ? PAT_W : len;
        t_done = (le + GAP) * DIV + 1;
        for (int c = 1; c <= t_done; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("abort_out", 32'(out), 32'(0));
                check("abort_ready", 32'(ready), 32'(1));
                check("abort_busy", 32'(busy), 32'(0));
                check("abort_done", 32'(done), 32'(0));
                return;
            end
            e_out = (c <= le * DIV) ? p[PAT_W - 1 - (c - 1) / DIV] : 1'b0;
            check($sformatf("out_c%0d", c), 32'(out), 32'(e_out));
            check($sformatf("done_c%0d", c), 32'(done), 32'(c == t_done));
            check($sformatf("busy_c%0d", c), 32'(busy), 32'(c != t_done));
            check($sformatf("ready_c%0d", c), 32'(ready), 32'(c == t_done));
            if (c == ignore_at) begin
                start   = 1'b1;
                pattern = 16'($urandom);
                pat_len = 5'($urandom_range(0, 31));
            end
            if (c == ignore_at + 1) start = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] rp;
        int          rl;

        #1;
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out", 32'(out), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Letter S, then back-to-back O-ish with a stray start mid-transfer
        start = 1'b1; pattern = 16'hA800; pat_len = 5'd5;
        run_char(16'hA800, 5, 0, 0);
        start = 1'b1; pattern = 16'hE000; pat_len = 5'd3;
        run_char(16'hE000, 3, 6, 0);

        // Degenerate lengths
        start = 1'b1; pattern = 16'hFFFF; pat_len = 5'd0;
        run_char(16'hFFFF, 0, 0, 0);
        start = 1'b1; pattern = 16'hFFFF; pat_len = 5'd31;
        run_char(16'hFFFF, 31, 0, 0);

        // Reset mid-SEND, then a clean resend
        @(negedge clk);
        start = 1'b1; pattern = 16'hA800; pat_len = 5'd5;
        run_char(16'hA800, 5, 0, 7);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'(0));
            check("post_rst_ready", 32'(ready), 32'(1));
        end
        start = 1'b1; pattern = 16'hA800; pat_len = 5'd5;
        run_char(16'hA800, 5, 0, 0);

        // Random characters with stray starts
        for (int n = 0; n < 6; n++) begin
            rp = 16'($urandom);
            rl = int'($urandom_range(0, 31));
            start = 1'b1; pattern = rp; pat_len = 5'(rl);
            run_char(rp, rl, int'($urandom_range(2, 8)), 0);
        end

        // DIV=1, GAP=0 instance: one bit per clock, then zero-length back-to-back
        @(negedge clk);
        start1 = 1'b1; pattern1 = 16'hB000; pat_len1 = 5'd4;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
            check($sformatf("d1_out_c%0d", c), 32'(out1),
                  32'((c <= 4) ? pattern1[PAT_W - c] : 1'b0));
            check($sformatf("d1_done_c%0d", c), 32'(done1), 32'(c == 5));
            check($sformatf("d1_busy_c%0d", c), 32'(busy1), 32'(c != 5));
        end
        start1 = 1'b1; pat_len1 = 5'd0;
        @(negedge clk);
        start1 = 1'b0;
        check("d1_len0_done", 32'(done1), 32'(1));
        check("d1_len0_busy", 32'(busy1), 32'(0));
        @(negedge clk);
        check("d1_len0_done_clr", 32'(done1), 32'(0));

`ifdef MORSE_TX_REPEAT_EN
        // Repeat loop: boundaries every (1+GAP)*DIV = 16 cycles, dropped after cycle 40
        rpt = 1'b1; start = 1'b1; pattern = 16'h8000; pat_len = 5'd1;
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check($sformatf("rp_out_c%0d", c), 32'(out), 32'(((c - 1) % 16) < 4 && c < 49));
            check($sformatf("rp_done_c%0d", c), 32'(done), 32'(c == 17 || c == 33 || c == 49));
            check($sformatf("rp_ready_c%0d", c), 32'(ready), 32'(c == 49));
            if (c == 40) rpt = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
